// File: rtl/soc_bus_fabric.sv
// -----------------------------------------------------------------------------
// soc_bus_fabric
//   Address decoder / response mux between a core's instruction bus (I-bus,
//   read-only) and data bus (D-bus), plus a small GPIO register block that
//   lives directly on the D-bus. The two buses are fully independent.
//
//   I-bus windows : RAM, ROM          D-bus windows : RAM, GPIO
//   Any access outside the windows of its bus completes one cycle after it is
//   sampled, with rdata = 0 and no side effects.
//
// Ports
//   clk, rst_n                     clock (rising edge), async active-low reset
//   im_* / dm_*                    master side: bstart, addr, (ttype), tsize,
//                                  (wdata) in; rdata, bdone out
//   d_ram_*, i_ram_*, i_rom_*      slave side: ss and forwarded controls out,
//                                  bdone / rdata in
//   gpio_in                        pin inputs (asynchronous to clk)
//   gpio_out, gpio_oe              OUT and DIR registers
//
// GPIO map (word offsets): 0x0 OUT rw, 0x4 IN ro, 0x8 DIR rw, 0xC reads 0.
// -----------------------------------------------------------------------------
module soc_bus_fabric #(
   parameter logic [31:0] RAM_BASE  = 32'h0000_0000,
   parameter logic [31:0] RAM_SIZE  = 32'h0000_4000,
   parameter logic [31:0] ROM_BASE  = 32'h2000_0000,
   parameter logic [31:0] ROM_SIZE  = 32'h0000_1000,
   parameter logic [31:0] GPIO_BASE = 32'h1000_0000,
   parameter logic [31:0] GPIO_SIZE = 32'h0000_0010
) (
   input  logic        clk,
   input  logic        rst_n,
   // I-bus master
   input  logic        im_bstart,
   input  logic [31:0] im_addr,
   input  logic [1:0]  im_tsize,
   output logic [31:0] im_rdata,
   output logic        im_bdone,
   // D-bus master
   input  logic        dm_bstart,
   input  logic [31:0] dm_addr,
   input  logic        dm_ttype,
   input  logic [1:0]  dm_tsize,
   input  logic [31:0] dm_wdata,
   output logic [31:0] dm_rdata,
   output logic        dm_bdone,
   // slave selects
   output logic        d_ram_ss,
   output logic        i_ram_ss,
   output logic        i_rom_ss,
   // slave responses
   input  logic        d_ram_bdone,
   input  logic [31:0] d_ram_rdata,
   input  logic        i_ram_bdone,
   input  logic [31:0] i_ram_rdata,
   input  logic        i_rom_bdone,
   input  logic [31:0] i_rom_rdata,
   // forwarded master controls
   output logic [31:0] d_ram_addr,
   output logic        d_ram_ttype,
   output logic [1:0]  d_ram_tsize,
   output logic [31:0] d_ram_wdata,
   output logic [31:0] i_ram_addr,
   output logic [1:0]  i_ram_tsize,
   output logic [31:0] i_rom_addr,
   output logic [1:0]  i_rom_tsize,
   // GPIO pins
   input  logic [31:0] gpio_in,
   output logic [31:0] gpio_out,
   output logic [31:0] gpio_oe
);

   // Window hit: base <= addr < base + size, written to avoid overflow at the
   // top of the address space.
   function automatic logic win_hit(input logic [31:0] addr,
                                    input logic [31:0] base,
                                    input logic [31:0] size);
      return (addr >= base) && ((addr - base) < size);
   endfunction

   // Byte-lane mask for a lane-aligned write of the given size.
   function automatic logic [31:0] lane_mask(input logic [1:0] tsize,
                                             input logic [1:0] a);
      logic [31:0] m;
      case (tsize)
         2'd0:    m = 32'h0000_00FF << {a, 3'b000};
         2'd1:    m = a[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
         default: m = '1;
      endcase
      return m;
   endfunction

   // ---------------------------------------------------------------- decode
   logic d_ram_hit, d_gpio_hit, i_ram_hit, i_rom_hit;
   logic d_gpio_sel, d_unm_sel, i_unm_sel;

   always_comb begin
      d_ram_hit  = win_hit(dm_addr, RAM_BASE, RAM_SIZE);
      // RAM takes priority so at most one D-bus select is ever active
      d_gpio_hit = win_hit(dm_addr, GPIO_BASE, GPIO_SIZE) && !d_ram_hit;
      i_ram_hit  = win_hit(im_addr, RAM_BASE, RAM_SIZE);
      i_rom_hit  = win_hit(im_addr, ROM_BASE, ROM_SIZE) && !i_ram_hit;
   end

   // Selects are gated by rst_n so they drop immediately on reset.
   assign d_ram_ss   = rst_n & dm_bstart & d_ram_hit;
   assign d_gpio_sel = rst_n & dm_bstart & d_gpio_hit;
   assign d_unm_sel  = rst_n & dm_bstart & !d_ram_hit & !d_gpio_hit;
   assign i_ram_ss   = rst_n & im_bstart & i_ram_hit;
   assign i_rom_ss   = rst_n & im_bstart & i_rom_hit;
   assign i_unm_sel  = rst_n & im_bstart & !i_ram_hit & !i_rom_hit;

   assign d_ram_addr  = dm_addr;
   assign d_ram_ttype = dm_ttype;
   assign d_ram_tsize = dm_tsize;
   assign d_ram_wdata = dm_wdata;
   assign i_ram_addr  = im_addr;
   assign i_ram_tsize = im_tsize;
   assign i_rom_addr  = im_addr;
   assign i_rom_tsize = im_tsize;

   // ------------------------------------------------- local response flags
   // A held request is accepted once; the done flag suppresses re-acceptance
   // on the edge that closes the bdone cycle, while bstart is still held.
   logic d_gpio_done_q, d_unm_done_q, i_unm_done_q;
   logic d_busy, d_gpio_acc, d_unm_acc, i_unm_acc;

   assign d_busy     = d_gpio_done_q | d_unm_done_q;
   assign d_gpio_acc = d_gpio_sel & !d_busy;
   assign d_unm_acc  = d_unm_sel & !d_busy;
   assign i_unm_acc  = i_unm_sel & !i_unm_done_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         d_gpio_done_q <= 1'b0;
         d_unm_done_q  <= 1'b0;
         i_unm_done_q  <= 1'b0;
      end else begin
         d_gpio_done_q <= d_gpio_acc;
         d_unm_done_q  <= d_unm_acc;
         i_unm_done_q  <= i_unm_acc;
      end
   end

   // ------------------------------------------------------------ GPIO block
   logic [31:0] out_q, dir_q, sync1_q, sync2_q, gpio_rdata_q;
   logic [31:0] wmask, gpio_rd;
   logic [1:0]  gpio_word;

   assign gpio_word = 2'((dm_addr - GPIO_BASE) >> 2);
   assign wmask     = lane_mask(dm_tsize, dm_addr[1:0]);

   always_comb begin
      gpio_rd = '0;
      case (gpio_word)
         2'd0:    gpio_rd = out_q;
         2'd1:    gpio_rd = sync2_q;
         2'd2:    gpio_rd = dir_q;
         default: gpio_rd = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= gpio_in;
         sync2_q <= sync1_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q        <= '0;
         dir_q        <= '0;
         gpio_rdata_q <= '0;
      end else if (d_gpio_acc) begin
         if (dm_ttype) begin
            gpio_rdata_q <= '0;
            case (gpio_word)
               2'd0:    out_q <= (out_q & ~wmask) | (dm_wdata & wmask);
               2'd2:    dir_q <= (dir_q & ~wmask) | (dm_wdata & wmask);
               default: ;
            endcase
         end else begin
            gpio_rdata_q <= gpio_rd;
         end
      end
   end

   assign gpio_out = out_q;
   assign gpio_oe  = dir_q;

   // --------------------------------------------------------- response mux
   always_comb begin
      dm_bdone = 1'b0;
      dm_rdata = '0;
      if (d_ram_ss) begin
         dm_bdone = d_ram_bdone;
         dm_rdata = d_ram_rdata;
      end else if (d_gpio_done_q) begin
         dm_bdone = 1'b1;
         dm_rdata = gpio_rdata_q;
      end else if (d_unm_done_q) begin
         dm_bdone = 1'b1;
      end
   end

   always_comb begin
      im_bdone = 1'b0;
      im_rdata = '0;
      if (i_ram_ss) begin
         im_bdone = i_ram_bdone;
         im_rdata = i_ram_rdata;
      end else if (i_rom_ss) begin
         im_bdone = i_rom_bdone;
         im_rdata = i_rom_rdata;
      end else if (i_unm_done_q) begin
         im_bdone = 1'b1;
      end
   end

endmodule

// File: tb/tb_soc_bus_fabric.sv
// -----------------------------------------------------------------------------
// tb_soc_bus_fabric
//   Self-checking bench for soc_bus_fabric: directed cases for the decode
//   windows, GPIO registers and reset, then randomized concurrent I/D traffic
//   compared against a behavioural model of the GPIO registers.
// -----------------------------------------------------------------------------
module tb_soc_bus_fabric;

   localparam logic [31:0] RAM_BASE  = 32'h0000_0000;
   localparam logic [31:0] RAM_SIZE  = 32'h0000_4000;
   localparam logic [31:0] ROM_BASE  = 32'h2000_0000;
   localparam logic [31:0] ROM_SIZE  = 32'h0000_1000;
   localparam logic [31:0] GPIO_BASE = 32'h1000_0000;
   localparam logic [31:0] GPIO_SIZE = 32'h0000_0010;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        im_bstart, dm_bstart, dm_ttype;
   logic [31:0] im_addr, dm_addr, dm_wdata;
   logic [1:0]  im_tsize, dm_tsize;
   logic [31:0] im_rdata, dm_rdata;
   logic        im_bdone, dm_bdone;
   logic        d_ram_ss, i_ram_ss, i_rom_ss;
   logic        d_ram_bdone, i_ram_bdone, i_rom_bdone;
   logic [31:0] d_ram_rdata, i_ram_rdata, i_rom_rdata;
   logic [31:0] d_ram_addr, d_ram_wdata, i_ram_addr, i_rom_addr;
   logic        d_ram_ttype;
   logic [1:0]  d_ram_tsize, i_ram_tsize, i_rom_tsize;
   logic [31:0] gpio_in, gpio_out, gpio_oe;

   always #5 clk = ~clk;

   soc_bus_fabric #(
      .RAM_BASE (RAM_BASE),  .RAM_SIZE (RAM_SIZE),
      .ROM_BASE (ROM_BASE),  .ROM_SIZE (ROM_SIZE),
      .GPIO_BASE(GPIO_BASE), .GPIO_SIZE(GPIO_SIZE)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .im_bstart(im_bstart), .im_addr(im_addr), .im_tsize(im_tsize),
      .im_rdata(im_rdata), .im_bdone(im_bdone),
      .dm_bstart(dm_bstart), .dm_addr(dm_addr), .dm_ttype(dm_ttype),
      .dm_tsize(dm_tsize), .dm_wdata(dm_wdata),
      .dm_rdata(dm_rdata), .dm_bdone(dm_bdone),
      .d_ram_ss(d_ram_ss), .i_ram_ss(i_ram_ss), .i_rom_ss(i_rom_ss),
      .d_ram_bdone(d_ram_bdone), .d_ram_rdata(d_ram_rdata),
      .i_ram_bdone(i_ram_bdone), .i_ram_rdata(i_ram_rdata),
      .i_rom_bdone(i_rom_bdone), .i_rom_rdata(i_rom_rdata),
      .d_ram_addr(d_ram_addr), .d_ram_ttype(d_ram_ttype),
      .d_ram_tsize(d_ram_tsize), .d_ram_wdata(d_ram_wdata),
      .i_ram_addr(i_ram_addr), .i_ram_tsize(i_ram_tsize),
      .i_rom_addr(i_rom_addr), .i_rom_tsize(i_rom_tsize),
      .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe)
   );

   int checks   = 0;
   int failures = 0;

   // Reference state: GPIO registers and the stable pin value.
   logic [31:0] m_out = '0;
   logic [31:0] m_dir = '0;
   logic [31:0] m_in  = '0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic bit in_win(input logic [31:0] a, input logic [31:0] base,
                                 input logic [31:0] size);
      return (a >= base) && (a < base + size);
   endfunction

   // Byte-by-byte write merge from the lane rules.
   function automatic logic [31:0] m_merge(input logic [31:0] old,
                                           input logic [31:0] wd,
                                           input logic [1:0] ts,
                                           input logic [31:0] a);
      logic [31:0] r = old;
      for (int b = 0; b < 4; b++) begin
         bit take;
         take = (ts == 2'd2) || (ts == 2'd1 && (b / 2) == int'(a[1]))
                || (ts == 2'd0 && b == int'(a[1:0]));
         if (take) r[b*8 +: 8] = wd[b*8 +: 8];
      end
      return r;
   endfunction

   // D-bus transfer: kind 0 RAM, 1 GPIO, 2 unmapped.
   task automatic d_txn(input logic [31:0] addr, input logic wr,
                        input logic [1:0] ts, input logic [31:0] wd);
      int kind, n, lat;
      logic [31:0] exp_rd, rv;
      if (in_win(addr, RAM_BASE, RAM_SIZE))        kind = 0;
      else if (in_win(addr, GPIO_BASE, GPIO_SIZE)) kind = 1;
      else                                         kind = 2;
      @(negedge clk);
      dm_bstart = 1'b1; dm_addr = addr; dm_ttype = wr; dm_tsize = ts; dm_wdata = wd;
      #1;
      check("d_ram_ss", 32'(d_ram_ss), 32'(kind == 0));
      if (kind == 0) begin
         check("d_fwd_addr", d_ram_addr, addr);
         check("d_fwd_ctl", 32'({d_ram_ttype, d_ram_tsize}), 32'({wr, ts}));
         check("d_fwd_wdata", d_ram_wdata, wd);
         lat = int'($urandom_range(0, 2));
         repeat (lat) begin
            check("d_ram_wait", 32'(dm_bdone), 32'd0);
            @(posedge clk); #1;
         end
         rv = $urandom;
         d_ram_rdata = rv; d_ram_bdone = 1'b1;
         #1;
         check("d_ram_bdone", 32'(dm_bdone), 32'd1);
         check("d_ram_rdata", dm_rdata, rv);
         @(posedge clk); #1;
         d_ram_bdone = 1'b0;
      end else begin
         check("d_early_bdone", 32'(dm_bdone), 32'd0);
         exp_rd = '0;
         if (kind == 1) begin
            case ((addr - GPIO_BASE) / 4)
               0: exp_rd = m_out;
               1: exp_rd = m_in;
               2: exp_rd = m_dir;
               default: exp_rd = '0;
            endcase
         end
         n = 0;
         do begin
            @(posedge clk); #1; n++;
         end while (!dm_bdone && n < 4);
         check("d_latency", 32'(n), 32'd1);
         if (!(kind == 1 && wr)) check("d_rdata", dm_rdata, exp_rd);
         if (kind == 1 && wr) begin
            if ((addr - GPIO_BASE) / 4 == 0) m_out = m_merge(m_out, wd, ts, addr);
            if ((addr - GPIO_BASE) / 4 == 2) m_dir = m_merge(m_dir, wd, ts, addr);
         end
         check("gpio_out", gpio_out, m_out);
         check("gpio_oe", gpio_oe, m_dir);
         @(posedge clk); #1;
         check("d_pulse", 32'(dm_bdone), 32'd0);
      end
      dm_bstart = 1'b0;
   endtask

   // I-bus transfer: kind 0 RAM, 1 ROM, 2 unmapped.
   task automatic i_txn(input logic [31:0] addr, input logic [1:0] ts);
      int kind, n, lat;
      logic [31:0] rv;
      if (in_win(addr, RAM_BASE, RAM_SIZE))      kind = 0;
      else if (in_win(addr, ROM_BASE, ROM_SIZE)) kind = 1;
      else                                       kind = 2;
      @(negedge clk);
      im_bstart = 1'b1; im_addr = addr; im_tsize = ts;
      #1;
      check("i_ram_ss", 32'(i_ram_ss), 32'(kind == 0));
      check("i_rom_ss", 32'(i_rom_ss), 32'(kind == 1));
      if (kind != 2) begin
         check("i_fwd", (kind == 0) ? i_ram_addr : i_rom_addr, addr);
         check("i_fwd_tsize", 32'((kind == 0) ? i_ram_tsize : i_rom_tsize), 32'(ts));
         lat = int'($urandom_range(0, 2));
         repeat (lat) begin
            check("i_wait", 32'(im_bdone), 32'd0);
            @(posedge clk); #1;
         end
         rv = $urandom;
         if (kind == 0) begin i_ram_rdata = rv; i_ram_bdone = 1'b1; end
         else           begin i_rom_rdata = rv; i_rom_bdone = 1'b1; end
         #1;
         check("i_bdone", 32'(im_bdone), 32'd1);
         check("i_rdata", im_rdata, rv);
         @(posedge clk); #1;
         i_ram_bdone = 1'b0; i_rom_bdone = 1'b0;
      end else begin
         check("i_early_bdone", 32'(im_bdone), 32'd0);
         n = 0;
         do begin
            @(posedge clk); #1; n++;
         end while (!im_bdone && n < 4);
         check("i_latency", 32'(n), 32'd1);
         check("i_rdata_unm", im_rdata, 32'd0);
         @(posedge clk); #1;
         check("i_pulse", 32'(im_bdone), 32'd0);
      end
      im_bstart = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a;
      logic [1:0]  ts;
      logic [31:0] ia;
      rst_n = 1'b0;
      im_bstart = 1'b1; im_addr = 32'h2000_0000; im_tsize = 2'd2;
      dm_bstart = 1'b1; dm_addr = 32'h0000_0100; dm_ttype = 1'b0;
      dm_tsize = 2'd2; dm_wdata = '0;
      d_ram_bdone = 1'b1; d_ram_rdata = '0;
      i_ram_bdone = 1'b0; i_ram_rdata = '0;
      i_rom_bdone = 1'b1; i_rom_rdata = '0;
      gpio_in = '0;
      #3;
      check("rst_d_ram_ss", 32'(d_ram_ss), 32'd0);
      check("rst_i_rom_ss", 32'(i_rom_ss), 32'd0);
      check("rst_dm_bdone", 32'(dm_bdone), 32'd0);
      check("rst_im_bdone", 32'(im_bdone), 32'd0);
      check("rst_gpio_out", gpio_out, 32'd0);
      check("rst_gpio_oe", gpio_oe, 32'd0);
      dm_bstart = 1'b0; im_bstart = 1'b0;
      d_ram_bdone = 1'b0; i_rom_bdone = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk); rst_n = 1'b1;

      // decode of the basic windows and boundaries
      d_txn(32'h0000_0100, 1'b0, 2'd2, 32'h0);
      i_txn(32'h2000_0000, 2'd2);
      i_txn(32'h0000_0010, 2'd2);
      d_txn(32'h0000_3FFC, 1'b0, 2'd2, 32'h0);
      d_txn(32'h0000_4000, 1'b0, 2'd2, 32'h0);
      d_txn(32'h1000_000C, 1'b0, 2'd2, 32'h0);
      d_txn(32'h1000_0010, 1'b0, 2'd2, 32'h0);
      d_txn(32'h2000_0000, 1'b0, 2'd2, 32'h0);
      i_txn(32'h2000_0FFC, 2'd2);
      i_txn(32'h2000_1000, 2'd2);

      // GPIO write lanes
      d_txn(32'h1000_0000, 1'b1, 2'd2, 32'hDEAD_BEEF);
      check("gpio_word_wr", gpio_out, 32'hDEAD_BEEF);
      d_txn(32'h1000_0002, 1'b1, 2'd0, 32'h0055_0000);
      check("gpio_byte_wr", gpio_out, 32'hDE55_BEEF);

      // IN register through the synchronizer
      @(negedge clk); gpio_in = 32'h0000_A5A5; m_in = gpio_in;
      repeat (2) @(posedge clk);
      d_txn(32'h1000_0004, 1'b0, 2'd2, 32'h0);

      // unmapped accesses leave GPIO untouched
      d_txn(32'h3000_0000, 1'b1, 2'd2, 32'h1234_5678);
      i_txn(32'h1000_0000, 2'd2);

      // reset in the middle of a GPIO write
      d_txn(32'h1000_0008, 1'b1, 2'd2, 32'h0000_00FF);
      check("dir_ff", gpio_oe, 32'h0000_00FF);
      @(negedge clk);
      dm_bstart = 1'b1; dm_addr = 32'h1000_0000; dm_ttype = 1'b1;
      dm_tsize = 2'd2; dm_wdata = 32'h1111_2222;
      #1; rst_n = 1'b0; #1;
      m_out = '0; m_dir = '0;
      check("rst_mid_oe", gpio_oe, 32'd0);
      check("rst_mid_out", gpio_out, 32'd0);
      check("rst_mid_bdone", 32'(dm_bdone), 32'd0);
      repeat (2) begin
         @(posedge clk); #1;
         check("rst_hold_bdone", 32'(dm_bdone), 32'd0);
         check("rst_hold_out", gpio_out, 32'd0);
      end
      dm_bstart = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      repeat (2) @(posedge clk);
      d_txn(32'h1000_0004, 1'b0, 2'd2, 32'h0);

      // randomized concurrent traffic
      for (int it = 0; it < 150; it++) begin
         if ($urandom_range(0, 7) == 0) begin
            @(negedge clk); gpio_in = $urandom; m_in = gpio_in;
            repeat (2) @(posedge clk);
         end
         ts = 2'($urandom_range(0, 2));
         case ($urandom_range(0, 3))
            0: a = $urandom_range(0, int'(RAM_SIZE) - 1);
            1, 2: a = GPIO_BASE + $urandom_range(0, 15);
            default: begin
               case ($urandom_range(0, 3))
                  0: a = ROM_BASE + $urandom_range(0, 32'hFFF);
                  1: a = 32'h3000_0000 + $urandom_range(0, 32'hFFFF);
                  2: a = RAM_SIZE + $urandom_range(0, 32'hFF);
                  default: a = GPIO_BASE + GPIO_SIZE + $urandom_range(0, 32'hFF);
               endcase
            end
         endcase
         a = a & ~((32'd1 << ts) - 32'd1);
         case ($urandom_range(0, 2))
            0: ia = $urandom_range(0, int'(RAM_SIZE) - 1);
            1: ia = ROM_BASE + $urandom_range(0, 32'hFFF);
            default: ia = (($urandom_range(0, 1) == 0) ? GPIO_BASE : ROM_BASE + ROM_SIZE)
                          + $urandom_range(0, 32'hFF);
         endcase
         ia = ia & ~32'd3;
         fork
            d_txn(a, 1'($urandom_range(0, 1)), ts, $urandom);
            i_txn(ia, 2'd2);
         join
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/soc_bus_fabric.md
SOC_BUS_FABRIC -- requirements
Module: soc_bus_fabric

Interface
REQ-001 SHALL have parameters, one per line:
- RAM_BASE 32'h0000_0000, RAM window base (I-bus and D-bus)
- RAM_SIZE 32'h0000_4000, RAM window bytes
- ROM_BASE 32'h2000_0000, ROM window base (I-bus only; core reset PC)
- ROM_SIZE 32'h0000_1000, ROM window bytes
- GPIO_BASE 32'h1000_0000, GPIO window base (D-bus only)
- GPIO_SIZE 32'h0000_0010, GPIO window bytes
REQ-002 SHALL have one clock; reset is asynchronous and active-low; ports named clk and rst_n.
REQ-003 SHALL have ports, one per line (name direction width meaning):
- clk  in  1  clock, rising edge
- rst_n  in  1  async active-low reset
- {i,d}m_bstart  in  1  master request strobe, held until bdone
- {i,d}m_addr  in  32  byte address
- dm_ttype  in  1  0=READ 1=WRITE (I-bus is read-only)
- {i,d}m_tsize  in  2  0=BYTE 1=HALFWORD 2=WORD
- dm_wdata  in  32  write data, lane-aligned
- {i,d}m_rdata  out  32  read data
- {i,d}m_bdone  out  1  transfer complete, one-cycle pulse
- d_ram_ss, i_ram_ss, i_rom_ss  out  1 each  slave selects
- {d_ram,i_ram,i_rom}_bdone / _rdata  in  1 / 32  slave responses
- d_ram_{addr,ttype,tsize,wdata}, i_ram_/i_rom_{addr,tsize}  out  forwarded master controls
- gpio_in  in  32  pin inputs
- gpio_out  out  32  output register
- gpio_oe  out  32  direction register (1=drive)

Function
REQ-004 SHALL decode addr combinationally: a slave is hit when BASE <= addr < BASE+SIZE.
REQ-005 D-bus SHALL assert exactly one of d_ram_ss / internal GPIO select while dm_bstart=1 and addr hits; I-bus likewise for i_ram_ss / i_rom_ss.
REQ-006 All ss outputs SHALL be 0 when the corresponding bstart=0.
REQ-007 Master bdone/rdata SHALL be muxed combinationally from the hit slave; address/controls forwarded unmodified.
REQ-008 Unmapped access (bstart=1, no hit, or dm_ttype=WRITE to ROM window on D-bus not mapped): no ss asserted, bdone pulses one cycle after bstart sampled, rdata=0, no state change.
REQ-009 I-bus and D-bus SHALL operate independently and concurrently; no arbitration inside this block (RAM is dual-port).
REQ-010 GPIO registers at word offsets: 0x0 OUT (rw), 0x4 IN (ro), 0x8 DIR (rw), 0xC reads 0, writes ignored.
REQ-011 GPIO responds: bdone=1 exactly one cycle after the rising edge sampling select&bstart; read rdata valid with bdone.
REQ-012 GPIO writes honour tsize and addr[1:0]: BYTE updates lane addr[1:0], HALFWORD lane addr[1], WORD all; other bytes unchanged.
REQ-013 GPIO reads SHALL return full 32-bit register; master does lane extraction.
REQ-014 IN register = gpio_in passed through two-flop synchronizer (2-cycle latency); writes to IN ignored.
REQ-015 gpio_out = OUT register, gpio_oe = DIR register, both registered outputs.
REQ-016 After bdone the master SHALL deassert or start a new transfer; back-to-back transfers supported with one request per bdone.

Reset
REQ-017 On rst_n=0 (async): OUT=0, DIR=0, sync flops=0, all bdone=0, pending-response flags cleared; ss outputs 0 regardless of bstart.
REQ-018 Reset asserted mid-transfer SHALL abort it with no bdone; release is synchronous to clk.

Verification
REQ-019 dm_bstart, addr 0x0000_0100 READ WORD -> d_ram_ss=1, GPIO select=0; dm_rdata/bdone equal d_ram_rdata/bdone.
REQ-020 im_bstart, addr 0x2000_0000 -> i_rom_ss=1, i_ram_ss=0; im_addr 0x0000_0010 -> i_ram_ss=1.
REQ-021 D-bus WRITE WORD 0xDEADBEEF to 0x1000_0000 -> bdone next cycle, gpio_out=0xDEADBEEF; WRITE BYTE 0x55 to 0x1000_0002 -> gpio_out=0xDE55BEEF.
REQ-022 gpio_in=0x0000_A5A5, wait 2 cycles, READ 0x1000_0004 -> dm_rdata=0x0000_A5A5 with bdone.
REQ-023 dm_bstart to 0x3000_0000 -> no ss, bdone after 1 cycle, rdata=0, GPIO unchanged; im to 0x1000_0000 -> same.
REQ-024 Write DIR=0xFF then pulse rst_n low mid-transfer -> gpio_oe=0, gpio_out=0 immediately, no bdone.
